// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forwarding
// selects, the per-stage register-usage slot and the zero-register index.
package hazard_pkg;

  localparam int SLOT_REG_W = 5;
  localparam logic [SLOT_REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [SLOT_REG_W-1:0] rs1;
    logic [SLOT_REG_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } slot_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding comparator: matches one EX source register against
// the MEM and WB destinations, newest producer first.
module fwd_sel_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             ex_valid,
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output fwd_sel_t         sel
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = ex_valid && use_src && mem_valid && mem_reg_write &&
                   (mem_rd != ZR) && (mem_rd == src);
  assign wb_hit  = ex_valid && use_src && wb_valid && wb_reg_write &&
                   (wb_rd != ZR) && (wb_rd == src);

  always_comb begin
    sel = FWD_REG;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadow EX/MEM/WB
// metadata, EX forwarding selects, load-use stall, branch flush, perf counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regWrite,
  input  logic             id_memRead,
  input  logic             br_taken,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  generate
    if (BR_STAGE != 2 && BR_STAGE != 3) begin : g_bad_br_stage
      $error("hazard_fwd_unit: BR_STAGE must be 2 (EX) or 3 (MEM)");
    end
    if (REG_W != SLOT_REG_W) begin : g_bad_reg_w
      $error("hazard_fwd_unit: REG_W must match hazard_pkg::SLOT_REG_W");
    end
  endgenerate

  localparam logic [REG_W-1:0] ZR        = REG_W'(ZERO_REG);
  localparam bit               BR_IN_MEM = (BR_STAGE == 3);

  slot_t ex, mem, wb;
  slot_t id_slot, ex_next, mem_next;

  logic active;
  logic br_slot_valid;
  logic br_q;
  logic load_use;
  logic stall;
  fwd_sel_t fwd_a, fwd_b;
  logic slot_unused;

  // Outputs are held quiet while reset is asserted so a reset mid-stall or
  // mid-flush never lets a stale request escape.
  assign active = ~reset;

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.rd        = id_rd;
    id_slot.reg_write = id_regWrite;
    id_slot.mem_read  = id_memRead;
    id_slot.rs1       = id_rs1;
    id_slot.rs2       = id_rs2;
    id_slot.use_rs1   = id_use_rs1;
    id_slot.use_rs2   = id_use_rs2;
  end

  assign br_slot_valid = BR_IN_MEM ? mem.valid : ex.valid;
  assign br_q          = active && br_taken && br_slot_valid;

  assign load_use = active && id_valid && ex.valid && ex.mem_read && (ex.rd != ZR) &&
                    ((id_use_rs1 && (id_rs1 == ex.rd)) ||
                     (id_use_rs2 && (id_rs2 == ex.rd)));

  // A taken branch discards the consumer anyway, so it suppresses the stall.
  assign stall = load_use && !br_q;

  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_D = br_q;
  assign flush_E = br_q;
  assign flush_M = br_q && BR_IN_MEM;

  assign ex_next  = (stall || flush_E) ? '0 : id_slot;
  assign mem_next = flush_M ? '0 : ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex        <= '0;
      mem       <= '0;
      wb        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex  <= ex_next;
      mem <= mem_next;
      wb  <= mem;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_q && (flush_cnt != '1))  flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  fwd_sel_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .ex_valid      (ex.valid && active),
    .use_src       (ex.use_rs1),
    .src           (ex.rs1),
    .mem_valid     (mem.valid),
    .mem_reg_write (mem.reg_write),
    .mem_rd        (mem.rd),
    .wb_valid      (wb.valid),
    .wb_reg_write  (wb.reg_write),
    .wb_rd         (wb.rd),
    .sel           (fwd_a)
  );

  fwd_sel_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .ex_valid      (ex.valid && active),
    .use_src       (ex.use_rs2),
    .src           (ex.rs2),
    .mem_valid     (mem.valid),
    .mem_reg_write (mem.reg_write),
    .mem_rd        (mem.rd),
    .wb_valid      (wb.valid),
    .wb_reg_write  (wb.reg_write),
    .wb_rd         (wb.rd),
    .sel           (fwd_b)
  );

  assign fwdA = fwd_a;
  assign fwdB = fwd_b;

  // WB source fields ride along for debug visibility but drive no logic.
  assign slot_unused = ^{wb.mem_read, wb.rs1, wb.rs2, wb.use_rs1, wb.use_rs2};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench: one MEM-resolving instance (32-bit counters) and one
// EX-resolving instance (2-bit counters for saturation) share the ID stimulus.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regWrite, id_memRead, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_F_3, stall_D_3, flush_D_3, flush_E_3, flush_M_3;
  logic [1:0]  fwdA_3, fwdB_3;
  logic [31:0] stall_cnt_3, flush_cnt_3;
  logic        stall_F_2, stall_D_2, flush_D_2, flush_E_2, flush_M_2;
  logic [1:0]  fwdA_2, fwdB_2;
  logic [1:0]  stall_cnt_2, flush_cnt_2;
  logic [8:0]  ctl3, ctl2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.REG_W(5), .ZERO_REG(31), .BR_STAGE(3), .CNT_W(32)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .br_taken(br_taken),
    .stall_F(stall_F_3), .stall_D(stall_D_3), .flush_D(flush_D_3), .flush_E(flush_E_3),
    .flush_M(flush_M_3), .fwdA(fwdA_3), .fwdB(fwdB_3),
    .stall_cnt(stall_cnt_3), .flush_cnt(flush_cnt_3));

  hazard_fwd_unit #(.REG_W(5), .ZERO_REG(31), .BR_STAGE(2), .CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .br_taken(br_taken),
    .stall_F(stall_F_2), .stall_D(stall_D_2), .flush_D(flush_D_2), .flush_E(flush_E_2),
    .flush_M(flush_M_2), .fwdA(fwdA_2), .fwdB(fwdB_2),
    .stall_cnt(stall_cnt_2), .flush_cnt(flush_cnt_2));

  assign ctl3 = {stall_F_3, stall_D_3, flush_D_3, flush_E_3, flush_M_3, fwdA_3, fwdB_3};
  assign ctl2 = {stall_F_2, stall_D_2, flush_D_2, flush_E_2, flush_M_2, fwdA_2, fwdB_2};

  function automatic logic [8:0] ctl(input bit sf, input bit sd, input bit fd, input bit fe,
                                     input bit fm, input logic [1:0] fa, input logic [1:0] fb);
    return {sf, sd, fd, fe, fm, fa, fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] rd,
                        input bit rw, input bit mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regWrite = rw; id_memRead = mr;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; br_taken = 1'b0; nop();
    tick(); tick();
    @(negedge clk);
    chk("reset ctl u3", ctl3, 9'd0);
    chk("reset ctl u2", ctl2, 9'd0);
    chk("reset cnts u3", {stall_cnt_3[15:0], flush_cnt_3[15:0]}, 32'd0);
    chk("reset cnts u2", {stall_cnt_2, flush_cnt_2}, 32'd0);
    tick(); reset = 1'b0;

    // ADD X1 then SUB X5,X1,X6: MEM forward on A
    set_id(1, 2, 3, 1, 1, 1, 1, 0); tick();
    set_id(1, 1, 6, 1, 1, 5, 1, 0); tick();
    set_id(0, 1, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("fwd mem u3", ctl3, ctl(0, 0, 0, 0, 0, 2'b10, 2'b00));
    chk("fwd mem u2", ctl2, ctl(0, 0, 0, 0, 0, 2'b10, 2'b00));
    tick(); nop();
    @(negedge clk);
    chk("invalid ex no fwd", {ctl3, ctl2}, 32'd0);

    // ADD X7, ORR, EOR X11,X12,X7: WB forward on B
    drain();
    set_id(1, 2, 3, 1, 1, 7, 1, 0); tick();
    set_id(1, 9, 10, 1, 1, 8, 1, 0); tick();
    set_id(1, 12, 7, 1, 1, 11, 1, 0); tick(); nop();
    @(negedge clk);
    chk("fwd wb B u3", ctl3, ctl(0, 0, 0, 0, 0, 2'b00, 2'b01));
    chk("fwd wb B u2", ctl2, ctl(0, 0, 0, 0, 0, 2'b00, 2'b01));

    // two writers of X13: MEM wins over WB; then non-writer / unused source
    drain();
    set_id(1, 2, 3, 1, 1, 13, 1, 0); tick();
    set_id(1, 2, 3, 1, 1, 13, 1, 0); tick();
    set_id(1, 13, 13, 1, 1, 12, 0, 0); tick();
    set_id(1, 12, 13, 1, 0, 14, 1, 0);
    @(negedge clk);
    chk("fwd prio", ctl3, ctl(0, 0, 0, 0, 0, 2'b10, 2'b10));
    tick(); nop();
    @(negedge clk);
    chk("no regwrite/no use", {ctl3, ctl2}, 32'd0);

    // LDUR X2 then ADD X3,X2,X4
    drain();
    set_id(1, 4, 0, 1, 0, 2, 1, 1); tick();
    set_id(1, 2, 4, 1, 1, 3, 1, 0);
    @(negedge clk);
    chk("load-use stall u3", ctl3, ctl(1, 1, 0, 0, 0, 2'b00, 2'b00));
    chk("load-use stall u2", ctl2, ctl(1, 1, 0, 0, 0, 2'b00, 2'b00));
    tick();
    @(negedge clk);
    chk("no re-stall", {ctl3, ctl2}, 32'd0);
    tick(); nop();
    @(negedge clk);
    chk("post-stall fwd wb", ctl3, ctl(0, 0, 0, 0, 0, 2'b01, 2'b00));
    chk("stall_cnt 1", {stall_cnt_3[15:0], 14'd0, stall_cnt_2}, {16'd1, 16'd1});

    // XZR producers never forward or stall
    drain();
    set_id(1, 4, 0, 1, 0, 31, 1, 1); tick();
    set_id(1, 31, 31, 1, 1, 6, 1, 0);
    @(negedge clk);
    chk("xzr no stall", {ctl3, ctl2}, 32'd0);
    tick(); set_id(1, 31, 31, 1, 1, 7, 1, 0);
    @(negedge clk);
    chk("xzr no fwd mem", {ctl3, ctl2}, 32'd0);
    tick(); nop();
    @(negedge clk);
    chk("xzr no fwd wb", {ctl3, ctl2}, 32'd0);

    // branch in EX taken: u2 flushes now, u3 (MEM slot empty) ignores
    drain();
    set_id(1, 1, 0, 1, 0, 0, 0, 0); tick();
    set_id(1, 0, 0, 0, 0, 9, 1, 0); br_taken = 1'b1;
    @(negedge clk);
    chk("br ex u2", ctl2, ctl(0, 0, 1, 1, 0, 2'b00, 2'b00));
    chk("br unqual u3", ctl3, 9'd0);
    tick();
    @(negedge clk);
    chk("br mem u3", ctl3, ctl(0, 0, 1, 1, 1, 2'b00, 2'b00));
    chk("br unqual u2", ctl2, 9'd0);
    tick(); br_taken = 1'b0; nop();
    @(negedge clk);
    chk("flush_cnt 1", {flush_cnt_3[15:0], 14'd0, flush_cnt_2}, {16'd1, 16'd1});

    // flush beats load-use stall
    drain();
    set_id(1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 4, 0, 1, 0, 5, 1, 1); tick();
    set_id(1, 5, 0, 1, 0, 6, 1, 0); br_taken = 1'b1;
    @(negedge clk);
    chk("flush>stall u3", ctl3, ctl(0, 0, 1, 1, 1, 2'b00, 2'b00));
    chk("flush>stall u2", ctl2, ctl(0, 0, 1, 1, 0, 2'b00, 2'b00));
    tick(); br_taken = 1'b0; nop();
    @(negedge clk);
    chk("stall_cnt held", {stall_cnt_3[15:0], 14'd0, stall_cnt_2}, {16'd1, 16'd1});
    chk("flush_cnt 2", {flush_cnt_3[15:0], 14'd0, flush_cnt_2}, {16'd2, 16'd2});

    // three more stalls: 2-bit counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      drain();
      set_id(1, 4, 0, 1, 0, 20, 1, 1); tick();
      set_id(1, 20, 0, 1, 0, 21, 1, 0);
      @(negedge clk);
      chk("sat loop stall", {stall_F_3, stall_F_2}, 32'd3);
      tick(); tick();
    end
    nop(); tick();
    @(negedge clk);
    chk("stall_cnt sat", {stall_cnt_3[15:0], 14'd0, stall_cnt_2}, {16'd4, 16'd3});

    // two more EX branches: u2 flush counter saturates, u3 never qualified
    for (int i = 0; i < 2; i++) begin
      drain();
      set_id(1, 0, 0, 0, 0, 0, 0, 0); tick();
      nop(); br_taken = 1'b1; tick();
      br_taken = 1'b0; tick();
    end
    @(negedge clk);
    chk("flush_cnt sat", {flush_cnt_3[15:0], 14'd0, flush_cnt_2}, {16'd2, 16'd3});

    // reset asserted during a stall
    drain();
    set_id(1, 4, 0, 1, 0, 20, 1, 1); tick();
    set_id(1, 20, 0, 1, 0, 21, 1, 0);
    @(negedge clk);
    chk("pre-reset stall", {stall_F_3, stall_D_3}, 32'd3);
    reset = 1'b1;
    tick(); reset = 1'b0; br_taken = 1'b1;
    @(negedge clk);
    chk("reset wins ctl", {ctl3, ctl2}, 32'd0);
    chk("reset wins cnt", {stall_cnt_3[7:0], flush_cnt_3[7:0], 12'd0, stall_cnt_2, flush_cnt_2}, 32'd0);
    br_taken = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined datapath (IF, ID, EX, MEM, WB).
- Keeps its own shadow pipeline of register-usage metadata for the EX, MEM and WB slots.
- From that metadata it generates EX-stage forwarding selects, load-use stalls and branch flushes.
- The branch resolution stage is selectable, and it provides saturating stall and flush performance counters.

Parameters:
- REG_W, 5, register index width.
- ZERO_REG, 31, index of XZR; never a forwarding or hazard source.
- BR_STAGE, 3, stage resolving branches: 2 = EX, 3 = MEM.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_W  ID source 1 index
- id_rs2  in  REG_W  ID source 2 index (post-reg2loc mux)
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_W  ID destination index
- id_regWrite  in  1  ID writes the register file
- id_memRead  in  1  ID is a load
- br_taken  in  1  branch in stage BR_STAGE resolved taken
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- flush_D  out  1  IF/ID loads bubble at next edge
- flush_E  out  1  ID/EX loads bubble at next edge
- flush_M  out  1  EX/MEM loads bubble at next edge
- fwdA  out  2  EX operand A select
- fwdB  out  2  EX operand B select
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- One clock domain. Reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset:
  - All slots are invalid.
  - stall_F, stall_D, flush_D, flush_E and flush_M are 0.
  - fwdA and fwdB are 00.
  - Both counters are 0.
  - A reset asserted mid-stall or mid-flush wins: the next cycle is fully clean.
- Slots: EX, MEM and WB each hold {valid, rd, regWrite, memRead, rs1, rs2}. rs1/rs2 are meaningful only with their use bits, which are also stored.
- Slot advance at each edge:
  - WB <= MEM.
  - MEM <= EX, or a bubble if flush_M.
  - EX <= ID fields with valid = id_valid, or a bubble if a stall or flush_E is active.
- Forwarding (combinational from slot registers, zero latency). fwdA:
  - 10 if MEM.valid, MEM.regWrite, MEM.rd != ZERO_REG, EX.use_rs1 and MEM.rd == EX.rs1.
  - Otherwise 01 if the same conditions hold against WB.
  - Otherwise 00.
  - MEM has priority over WB (newest value wins).
  - fwdB is identical on rs2.
  - An invalid EX slot forces 00.
- No ID-stage forwarding: the register file makes a WB-cycle write visible to the same-cycle ID read.
- Load-use stall condition: id_valid, EX.valid, EX.memRead, EX.rd != ZERO_REG, and either (id_use_rs1 and id_rs1 == EX.rd) or (id_use_rs2 and id_rs2 == EX.rd).
  - stall_F = stall_D = 1 for exactly one cycle.
  - EX receives a bubble.
  - Next cycle the load is in MEM, no re-stall occurs, and the consumer later forwards with 01 from WB.
- Branch: br_taken is qualified by the valid bit of slot BR_STAGE (EX for 2, MEM for 3); an unqualified assertion is ignored.
  - If BR_STAGE = 2: flush_D = flush_E = 1, flush_M = 0.
  - If BR_STAGE = 3: flush_D = flush_E = flush_M = 1.
  - Outputs are combinational in the same cycle.
- Flush beats stall: when a qualified br_taken coincides with a load-use condition, stall_F/stall_D = 0 and stall_cnt does not increment.
- Counters:
  - stall_cnt increments on each stall cycle.
  - flush_cnt increments on each qualified taken branch.
  - Both saturate at all-ones; there is no wrap.
- Any BR_STAGE outside {2, 3} is an elaboration error (assertion).

Decomposition:
- hazard_pkg contains:
  - fwd_sel_t enum: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - slot_t packed struct.
  - XZR constant.
- Sub-module fwd_sel_unit: combinational per-operand comparator (EX source vs MEM/WB slots -> fwd_sel_t), instantiated twice.

Test Plan:
- ADD X1 in EX->MEM, then SUB reading X1 in EX next cycle -> fwdA = 10.
  - Same with one independent instruction between -> fwdA = 01.
- LDUR X2 then ADD X3,X2,X4 back-to-back:
  - stall_F = stall_D = 1 for 1 cycle, EX bubble.
  - Next cycle no stall; ADD in EX sees fwdA = 01.
  - stall_cnt = 1.
- Write to X31 (ZERO_REG) followed by a reader of X31 -> fwdA = fwdB = 00, no stall.
- BR_STAGE = 3, qualified br_taken -> flush_D = flush_E = flush_M = 1 same cycle, flush_cnt += 1.
  - Repeat with BR_STAGE = 2 -> flush_M = 0.
- br_taken coincident with a load-use condition -> flush outputs = 1, stall_F = stall_D = 0, stall_cnt unchanged.
  - br_taken with the BR_STAGE slot invalid -> ignored.
- Preload stall_cnt near all-ones and force stalls -> holds all-ones.
  - Assert reset during a stall -> all outputs 0 next cycle.
